// File: rtl/bch_secded_dec_pipe.sv
// bch_secded_dec_pipe: two-stage streaming SEC-DED decoder with bypass, saturating stats and error log
module bch_secded_dec_pipe #(
    parameter int DATA_W = 128,
    parameter int CNT_W = 16,
    localparam int P = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic              i_bypass,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_err_corr,
    output logic              o_err_detec,
    output logic              o_err_fatal,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_corr_cnt,
    output logic [CNT_W-1:0]  o_uncorr_cnt,
    output logic              o_log_valid,
    output logic [P-1:0]      o_log_syn
);
    // Hamming position of data bit idx: non-power-of-two positions in ascending order from 3
    function automatic int data_pos(int idx);
        int n = 0;
        int pos = 0;
        for (int k = 3; k < CODE_W; k++)
            if ((k & (k - 1)) != 0) begin
                if (n == idx) pos = k;
                n++;
            end
        return pos;
    endfunction

    logic              w_adv;
    logic              w_hs;
    logic [P-1:0]      w_syn;
    logic [DATA_W-1:0] w_data_raw;
    logic [DATA_W-1:0] w_flip;
    logic              w_big;
    logic              w_corr;
    logic              w_detec;
    logic              w_fatal;
    logic              r_s1_valid;
    logic              r_s1_bypass;
    logic              r_s1_par;
    logic [P-1:0]      r_s1_syn;
    logic [DATA_W-1:0] r_s1_data;
    logic [P-1:0]      r_s2_syn;

    assign w_adv   = enable & (~o_valid | o_ready);
    assign w_hs    = o_valid & o_ready & enable;
    assign i_ready = w_adv & ~reset;

    // Syndrome: XOR of the positions of all set code bits above the overall parity bit
    always_comb begin
        w_syn = '0;
        for (int k = 1; k < CODE_W; k++)
            if (i_code[k]) w_syn ^= P'(k);
    end

    genvar g;
    for (g = 0; g < DATA_W; g++) begin : g_data
        localparam int POS = data_pos(g);
        assign w_data_raw[g] = i_code[POS];
        assign w_flip[g]     = 32'(r_s1_syn) == POS;
    end

    // s=0 with odd parity is an error in the overall parity bit and leaves data untouched
    assign w_big   = 32'(r_s1_syn) >= CODE_W;
    assign w_corr  = r_s1_par & ~w_big;
    assign w_detec = ~r_s1_par & |r_s1_syn;
    assign w_fatal = r_s1_par & w_big;

    // Both stages move together on advance and hold exactly otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_bypass <= 1'b0;
            r_s1_par    <= 1'b0;
            r_s1_syn    <= '0;
            r_s1_data   <= '0;
            r_s2_syn    <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_err_corr  <= 1'b0;
            o_err_detec <= 1'b0;
            o_err_fatal <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid  <= i_valid;
            r_s1_bypass <= i_bypass;
            r_s1_par    <= ^i_code;
            r_s1_syn    <= w_syn;
            r_s1_data   <= w_data_raw;
            r_s2_syn    <= r_s1_syn;
            o_valid     <= r_s1_valid;
            o_data      <= r_s1_data ^ (w_flip & {DATA_W{w_corr & ~r_s1_bypass}});
            o_err_corr  <= r_s1_valid & w_corr;
            o_err_detec <= r_s1_valid & w_detec;
            o_err_fatal <= r_s1_valid & w_fatal;
        end
    end

    // Statistics and first-uncorrectable log update on output handshake; clear dominates
    always_ff @(posedge clk) begin
        if (reset | i_cnt_clr) begin
            o_corr_cnt   <= '0;
            o_uncorr_cnt <= '0;
            o_log_valid  <= 1'b0;
            o_log_syn    <= '0;
        end else if (w_hs) begin
            o_corr_cnt   <= o_corr_cnt + CNT_W'(o_err_corr & ~&o_corr_cnt);
            o_uncorr_cnt <= o_uncorr_cnt + CNT_W'((o_err_detec | o_err_fatal) & ~&o_uncorr_cnt);
            if ((o_err_detec | o_err_fatal) & ~o_log_valid) begin
                o_log_valid <= 1'b1;
                o_log_syn   <= r_s2_syn;
            end
        end
    end
endmodule

// File: tb/tb_bch_secded_dec_pipe.sv
// tb_bch_secded_dec_pipe: scoreboard bench for the pipelined SEC-DED decoder
module tb_bch_secded_dec_pipe;
    localparam int DW = 128;
    localparam int PW = 8;
    localparam int CW = 137;
    localparam int NW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          c;
        logic          de;
        logic          f;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [CW-1:0] i_code;
    logic          i_valid;
    logic          i_ready;
    logic          i_bypass;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_ready;
    logic          o_err_corr;
    logic          o_err_detec;
    logic          o_err_fatal;
    logic          i_cnt_clr;
    logic [NW-1:0] o_corr_cnt;
    logic [NW-1:0] o_uncorr_cnt;
    logic          o_log_valid;
    logic [PW-1:0] o_log_syn;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];

    bch_secded_dec_pipe #(.DATA_W(DW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .i_code(i_code), .i_valid(i_valid), .i_ready(i_ready), .i_bypass(i_bypass),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
        .o_err_corr(o_err_corr), .o_err_detec(o_err_detec), .o_err_fatal(o_err_fatal),
        .i_cnt_clr(i_cnt_clr), .o_corr_cnt(o_corr_cnt), .o_uncorr_cnt(o_uncorr_cnt),
        .o_log_valid(o_log_valid), .o_log_syn(o_log_syn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input logic c, input logic de, input logic f);
        exp_t e;
        e.d = d;
        e.c = c;
        e.de = de;
        e.f = f;
        return e;
    endfunction

    function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
        logic [CW-1:0] c = '0;
        int j = 0;
        int s = 0;
        for (int k = 1; k < CW; k++)
            if ((k & (k - 1)) != 0) begin
                c[k] = d[j];
                j++;
            end
        for (int k = 1; k < CW; k++) if (c[k]) s ^= k;
        for (int b = 0; b < PW; b++) if (s[b]) c[1 << b] = 1'b1;
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic exp_t model(input logic [CW-1:0] c, input logic byp);
        exp_t e = '0;
        int s = 0;
        int j = 0;
        logic p;
        for (int k = 1; k < CW; k++) if (c[k]) s ^= k;
        p = ^c;
        e.c = p && s < CW;
        e.de = !p && s != 0;
        e.f = p && s >= CW;
        if (e.c && !byp && s != 0) c[s] = ~c[s];
        for (int k = 1; k < CW; k++)
            if ((k & (k - 1)) != 0) begin
                e.d[j] = c[k];
                j++;
            end
        return e;
    endfunction

    task automatic send(input logic [CW-1:0] c, input logic b, input exp_t e);
        bit ok = 0;
        i_code = c;
        i_bypass = b;
        i_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (i_ready) begin
                q.push_back(e);
                ok = 1;
            end
        end
        if (!ok) check("send_ready", i_ready, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_bypass = 1'b0;
    endtask

    task automatic send_rand(input int nerr, input logic b);
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int p1;
        int p2;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        c = enc(d);
        p1 = $urandom_range(0, CW - 1);
        p2 = (p1 + 1 + $urandom_range(0, CW - 2)) % CW;
        if (nerr >= 1) c[p1] = ~c[p1];
        if (nerr >= 2) c[p2] = ~c[p2];
        send(c, b, model(c, b));
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
        check("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        i_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && enable && o_valid && o_ready) begin
            check("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_data", o_data, e.d);
                check("out_flags", {o_err_corr, o_err_detec, o_err_fatal}, {e.c, e.de, e.f});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] c;
        reset = 1'b1;
        enable = 1'b1;
        o_ready = 1'b1;
        i_valid = 1'b0;
        i_code = '0;
        i_bypass = 1'b0;
        i_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_iready", i_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_flags", {o_err_corr, o_err_detec, o_err_fatal}, 0);
        check("rst_cnts", {o_corr_cnt, o_uncorr_cnt}, 0);
        check("rst_log", {o_log_valid, o_log_syn}, 0);
        reset = 1'b0;

        send('0, 1'b0, mk('0, 0, 0, 0));
        check("lat1_valid", o_valid, 0);
        @(posedge clk);
        #1;
        check("lat2_valid", o_valid, 1);
        check("lat2_data", o_data, 0);
        drain();
        check("clean_cnts", {o_corr_cnt, o_uncorr_cnt}, 0);

        c = '0; c[12] = 1'b1;
        send(c, 1'b0, mk('0, 1, 0, 0));
        drain();
        check("corr_cnt1", o_corr_cnt, 1);

        c = '0; c[16] = 1'b1; c[18] = 1'b1;
        send(c, 1'b0, mk(128'h1000, 0, 1, 0));
        drain();
        check("uncorr_cnt1", o_uncorr_cnt, 1);
        check("log_valid1", o_log_valid, 1);
        check("log_syn1", o_log_syn, 2);

        c = '0; c[20] = 1'b1; c[21] = 1'b1;
        send(c, 1'b0, mk(128'hC000, 0, 1, 0));
        drain();
        check("log_syn_kept", o_log_syn, 2);
        check("uncorr_cnt2", o_uncorr_cnt, 2);

        c = '0; c[128] = 1'b1; c[8] = 1'b1; c[1] = 1'b1;
        send(c, 1'b0, mk('0, 0, 0, 1));
        drain();
        check("uncorr_cnt3", o_uncorr_cnt, 3);
        check("log_syn_kept2", o_log_syn, 2);

        c = '0; c[12] = 1'b1;
        send(c, 1'b1, mk(128'h80, 1, 0, 0));
        drain();
        check("corr_cnt2", o_corr_cnt, 2);

        c = '0; c[0] = 1'b1;
        send(c, 1'b0, mk('0, 1, 0, 0));
        c = '0; c[3] = 1'b1;
        send(c, 1'b0, mk('0, 1, 0, 0));
        drain();
        check("corr_sat", o_corr_cnt, 3);
        check("uncorr_sat", o_uncorr_cnt, 3);

        clear();
        check("clr_cnts", {o_corr_cnt, o_uncorr_cnt}, 0);
        check("clr_log", {o_log_valid, o_log_syn}, 0);

        fork
            for (int i = 0; i < 4; i++) send_rand(i == 0 ? 0 : (i == 2 ? 2 : 1), 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                o_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_iready", i_ready, 0);
                    check("stall_valid", o_valid, 1);
                end
                @(posedge clk);
                #1;
                o_ready = 1'b1;
            end
        join
        drain();

        fork
            for (int i = 0; i < 4; i++) send_rand(i % 3, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                enable = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check("frz_iready", i_ready, 0);
                    check("frz_valid", o_valid, 1);
                end
                @(posedge clk);
                #1;
                enable = 1'b1;
            end
        join
        drain();

        fork
            for (int i = 0; i < 40; i++) send_rand($urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    o_ready = 1'($urandom_range(0, 2) != 0);
                end
                o_ready = 1'b1;
            end
        join
        drain();

        clear();
        for (int i = 0; i < 5; i++) send_rand(1, 1'b0);
        send_rand(2, 1'b0);
        drain();
        check("sat_corr", o_corr_cnt, 3);
        check("sat_uncorr", o_uncorr_cnt, 1);
        check("sat_logv", o_log_valid, 1);
        send_rand(1, 1'b0);
        @(posedge clk);
        #1;
        check("clr_hs_valid", o_valid, 1);
        i_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b0;
        check("clr_hs_corr", o_corr_cnt, 0);
        check("clr_hs_uncorr", o_uncorr_cnt, 0);
        check("clr_hs_log", {o_log_valid, o_log_syn}, 0);
        check("clr_hs_drained", q.size(), 0);

        send_rand(0, 1'b0);
        send_rand(1, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_iready", i_ready, 0);
        @(posedge clk);
        #1;
        check("midrst_valid", o_valid, 0);
        q.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", o_valid, 0);
        send_rand(1, 1'b0);
        drain();
        check("post_rst_corr", o_corr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bch_secded_dec_pipe.md
Name: bch_secded_dec_pipe

Overview:
- Parametrised, pipelined ECC decoder; successor to the fixed 128-bit DEC-TED decoder in the read datapath.
- Decodes an extended-Hamming SEC-DED codeword of configurable data width.
- Adds valid/ready streaming, a correction-bypass mode, saturating error statistics and a first-uncorrectable-error syndrome log.
- Sits between the memory read port and the consumer; one codeword per cycle at full throughput.

Parameters:
DATA_W, 128, data bits per codeword (>=4)
P, derived localparam: smallest integer with 2^P >= DATA_W+P+1 (P=8 for DATA_W=128)
CODE_W, derived localparam = DATA_W+P+1 (137 for DATA_W=128)
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  global advance enable; low freezes all state
i_code  input  CODE_W  codeword
i_valid  input  1  i_code valid
i_ready  output  1  block accepts i_code this cycle
i_bypass  input  1  per-word: pass data uncorrected, still report flags
o_data  output  DATA_W  decoded data
o_valid  output  1  o_data valid
o_ready  input  1  consumer accepts o_data
o_err_corr  output  1  single error corrected (or overall-parity-bit error)
o_err_detec  output  1  double error detected, not corrected
o_err_fatal  output  1  syndrome outside code range (>=3 errors)
i_cnt_clr  input  1  clear counters and log
o_corr_cnt  output  CNT_W  saturating count of o_err_corr words
o_uncorr_cnt  output  CNT_W  saturating count of o_err_detec or o_err_fatal words
o_log_valid  output  1  o_log_syn holds a captured syndrome
o_log_syn  output  P  syndrome of first uncorrectable word since last clear

Behaviour:
- Code layout: i_code[0] is the overall parity bit. Bit k (1..CODE_W-1) is Hamming position k. Check bits sit at power-of-two positions. Data bits fill the remaining positions in ascending order, with data[0] at position 3.
- Stage 1 registers code, bypass, syndrome s = XOR of k over set bits k>=1, and overall parity p = XOR of all bits.
- Stage 2 registers o_data and the flags. Latency is 2 advancing cycles.
- Classification: s=0,p=0 clean. s!=0,p=1,s<CODE_W flip bit s, corr=1. s=0,p=1 corr=1, data unchanged. s!=0,p=0 detec=1, data raw. s>=CODE_W,p=1 fatal=1, data raw.
- Flags are mutually exclusive.
- i_bypass=1: data raw regardless of class; flags and counters still update.
- Advance: adv = enable & (~o_valid | o_ready); i_ready = adv (combinational path from o_ready permitted).
- When adv=0, both stages hold contents exactly. Bubbles collapse when adv=1.
- Counters and log update only on output handshake (o_valid & o_ready & enable). Counters saturate at all-ones; no wrap.
- Log captures s on the first detec/fatal handshake while o_log_valid=0. Later errors do not overwrite it.
- i_cnt_clr zeroes counters, o_log_valid and o_log_syn. Clear wins over a same-cycle increment or capture; that word is not counted. Clear acts regardless of enable.
- Reset value of every output: o_valid=0, o_data=0, all flags=0, counters=0, o_log_valid=0, o_log_syn=0.
- Reset flushes in-flight words; i_ready is low during reset.
- o_data and flags are held stable while o_valid & ~o_ready.

Test Plan:
- DATA_W=128, i_code=0, i_valid for 1 cycle -> o_valid 2 cycles later, o_data=0, all flags 0, counters 0.
- i_code=1<<12 (data[7] flipped) -> o_data=0, o_err_corr=1, o_corr_cnt=1.
- i_code=(1<<16)|(1<<18) -> s=2, o_err_detec=1, o_data=1<<12, o_uncorr_cnt=1, o_log_valid=1, o_log_syn=2. A second double error leaves o_log_syn=2.
- i_code=(1<<128)|(1<<8)|(1<<1) -> s=137, o_err_fatal=1, o_data=0. Same word with i_bypass=1 and i_code=1<<12 -> o_data=1<<7, o_err_corr=1.
- Back-to-back 4 distinct words, o_ready low 3 cycles mid-stream -> i_ready low while stalled, all 4 words out in order, none lost or duplicated; enable low 2 cycles freezes identically.
- CNT_W=2, 5 single-error words -> o_corr_cnt=3 (saturated). i_cnt_clr asserted on the handshake of a 6th single-error word -> o_corr_cnt=0. Reset mid-stream -> o_valid=0 next cycle.
